// File: rtl/ast_edn_stub_multi_if.sv
// EDN request/response bundle between the top's EDN requesters (master) and the AST EDN stub (slave).
interface ast_edn_stub_multi_if #(
  parameter int NumCh = 2,
  parameter int BusW  = 32
);
  logic [NumCh-1:0]      req;
  logic [NumCh-1:0]      ack;
  logic [NumCh-1:0]      fips;
  logic [NumCh*BusW-1:0] bus;

  modport master (output req, input ack, fips, bus);
  modport slave  (input req, output ack, fips, bus);
endinterface

// File: rtl/ast_edn_stub_multi.sv
// Round-robin EDN entropy stub: ack AckLatency+1 cycles after a grant; requests held until ack, dropped req aborts.
// Optional AST_EDN_STUB_ERR_INJ_EN adds err_inj_i to corrupt the fips flag and entropy word of an ack.
module ast_edn_stub_multi #(
  parameter int          NumCh      = 2,
  parameter int          BusW       = 32,
  parameter int          AckLatency = 4,
  parameter logic [31:0] LfsrSeed   = 32'h0000_0001,
  parameter logic        FipsVal    = 1'b1,
  parameter logic [15:0] CntInit    = 16'h0000
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       enable_i,
`ifdef AST_EDN_STUB_ERR_INJ_EN
  input  logic                       err_inj_i,
`endif
  ast_edn_stub_multi_if.slave        edn,
  output logic                       busy_o,
  output logic [15:0]                served_cnt_o
);

  localparam int              PtrW    = (NumCh > 1) ? $clog2(NumCh) : 1;
  localparam logic [31:0]     SeedEff = (LfsrSeed == 32'h0) ? 32'h1 : LfsrSeed;
  localparam logic [PtrW-1:0] LastCh  = PtrW'(NumCh - 1);
  localparam logic [PtrW:0]   NumChW  = (PtrW + 1)'(NumCh);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_e;

  state_e                state_q;
  logic [7:0]            cnt_q;
  logic [PtrW-1:0]       rr_ptr_q;
  logic [PtrW-1:0]       gnt_q;
  logic [31:0]           lfsr_q;
  logic [15:0]           served_q;
  logic [NumCh-1:0]      ack_q;
  logic [NumCh-1:0]      fips_q;
  logic [NumCh*BusW-1:0] bus_q;
  logic                  busy_q;

  logic [2*NumCh-1:0]    req_dbl;
  logic [NumCh-1:0]      req_rot;
  logic [PtrW-1:0]       off;
  logic [PtrW:0]         gnt_sum;
  logic [PtrW-1:0]       gnt_idx_d;
  logic                  gnt_vld_d;
  logic [PtrW-1:0]       ack_ch_d;
  logic [31:0]           lfsr_d;
  logic [31:0]           word_d;
  logic                  fips_bit_d;
  logic [NumCh-1:0]      ack_vec_d;
  logic [NumCh-1:0]      fips_vec_d;
  logic [NumCh*BusW-1:0] bus_vec_d;

  // Rotate requests so bit 0 is the channel at rr_ptr, then pick the lowest set offset.
  assign req_dbl = {edn.req, edn.req};
  assign req_rot = NumCh'(req_dbl >> rr_ptr_q);

  always_comb begin
    gnt_vld_d = 1'b0;
    off       = '0;
    for (int i = NumCh - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        gnt_vld_d = 1'b1;
        off       = PtrW'(i);
      end
    end
    gnt_sum = {1'b0, rr_ptr_q} + {1'b0, off};
    if (gnt_sum >= NumChW) gnt_sum = gnt_sum - NumChW;
    gnt_idx_d = gnt_sum[PtrW-1:0];
  end

  assign lfsr_d   = (lfsr_q >> 1) ^ (lfsr_q[0] ? 32'h8020_0003 : 32'h0);
  assign ack_ch_d = (state_q == IDLE) ? gnt_idx_d : gnt_q;

  always_comb begin
    word_d     = lfsr_q;
    fips_bit_d = FipsVal;
`ifdef AST_EDN_STUB_ERR_INJ_EN
    if (err_inj_i) begin
      word_d     = ~lfsr_q;
      fips_bit_d = 1'b0;
    end
`endif
  end

  always_comb begin
    ack_vec_d  = '0;
    fips_vec_d = '0;
    bus_vec_d  = '0;
    for (int c = 0; c < NumCh; c++) begin
      if (PtrW'(c) == ack_ch_d) begin
        ack_vec_d[c]               = 1'b1;
        fips_vec_d[c]              = fips_bit_d;
        bus_vec_d[c*BusW +: BusW]  = BusW'(word_d);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      lfsr_q   <= SeedEff;
      served_q <= CntInit;
      ack_q    <= '0;
      fips_q   <= '0;
      bus_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      ack_q  <= '0;
      fips_q <= '0;
      bus_q  <= '0;
      unique case (state_q)
        IDLE: begin
          if (enable_i && gnt_vld_d) begin
            gnt_q  <= gnt_idx_d;
            busy_q <= 1'b1;
            if (AckLatency == 0) begin
              state_q <= ACK;
              ack_q   <= ack_vec_d;
              fips_q  <= fips_vec_d;
              bus_q   <= bus_vec_d;
            end else begin
              state_q <= WAIT;
              cnt_q   <= 8'(AckLatency - 1);
            end
          end
        end
        WAIT: begin
          if (!edn.req[gnt_q] || !enable_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q == 8'd0) begin
            state_q <= ACK;
            ack_q   <= ack_vec_d;
            fips_q  <= fips_vec_d;
            bus_q   <= bus_vec_d;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        ACK: begin
          state_q  <= IDLE;
          busy_q   <= 1'b0;
          lfsr_q   <= lfsr_d;
          rr_ptr_q <= (gnt_q == LastCh) ? '0 : gnt_q + 1'b1;
          if (served_q != 16'hFFFF) served_q <= served_q + 16'd1;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign edn.ack      = ack_q;
  assign edn.fips     = fips_q;
  assign edn.bus      = bus_q;
  assign busy_o       = busy_q;
  assign served_cnt_o = served_q;

endmodule

// File: tb/tb_ast_edn_stub_multi.sv
// Bench for ast_edn_stub_multi: directed steps on two configurations plus a randomized run against a transaction model.
module tb_ast_edn_stub_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        en0, en1;
  logic        busy0, busy1;
  logic [15:0] cnt0, cnt1;
`ifdef AST_EDN_STUB_ERR_INJ_EN
  logic        err0, err1;
`endif

  ast_edn_stub_multi_if #(.NumCh(2), .BusW(32)) e0 ();
  ast_edn_stub_multi_if #(.NumCh(3), .BusW(32)) e1 ();

  ast_edn_stub_multi #(
    .NumCh(2), .BusW(32), .AckLatency(4), .LfsrSeed(32'h0000_0001),
    .FipsVal(1'b1), .CntInit(16'h0000)
  ) u0 (
    .clk_i(clk), .rst_i(rst), .enable_i(en0),
`ifdef AST_EDN_STUB_ERR_INJ_EN
    .err_inj_i(err0),
`endif
    .edn(e0), .busy_o(busy0), .served_cnt_o(cnt0)
  );

  ast_edn_stub_multi #(
    .NumCh(3), .BusW(32), .AckLatency(0), .LfsrSeed(32'h0000_0000),
    .FipsVal(1'b1), .CntInit(16'hFFFE)
  ) u1 (
    .clk_i(clk), .rst_i(rst), .enable_i(en1),
`ifdef AST_EDN_STUB_ERR_INJ_EN
    .err_inj_i(err1),
`endif
    .edn(e1), .busy_o(busy1), .served_cnt_o(cnt1)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] lfsr_nx(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  logic [31:0] w;
  logic [1:0]  exp2;
  logic [2:0]  exp3;
  int          ch;

  // transaction-level reference state for the randomized run
  logic [1:0]  pend;
  bit          m_busy;
  bit          found;
  int          m_ch, m_ack, free_from, rr_m, cnt_m;
  logic [31:0] lf_m;

  initial begin
    rst = 1'b1; en0 = 1'b1; en1 = 1'b1;
    e0.req = '0; e1.req = '0;
`ifdef AST_EDN_STUB_ERR_INJ_EN
    err0 = 1'b0; err1 = 1'b0;
`endif
    repeat (3) step();
    chk("rst_ack0",  64'(e0.ack),  64'(0));
    chk("rst_fips0", 64'(e0.fips), 64'(0));
    chk("rst_bus0",  64'(e0.bus),  64'(0));
    chk("rst_busy0", 64'(busy0),   64'(0));
    chk("rst_cnt0",  64'(cnt0),    64'(0));
    chk("rst_ack1",  64'(e1.ack),  64'(0));
    chk("rst_busy1", 64'(busy1),   64'(0));
    chk("rst_cnt1",  64'(cnt1),    64'(16'hFFFE));

    // single request on ch0, latency 4 -> ack 5 cycles later
    rst = 1'b0; e0.req = 2'b01;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("single_noack", 64'(e0.ack), 64'(0));
      chk("single_busy",  64'(busy0),  64'(1));
    end
    step();
    chk("single_ack",  64'(e0.ack),       64'(2'b01));
    chk("single_w0",   64'(e0.bus[31:0]), 64'(32'h0000_0001));
    chk("single_w1z",  64'(e0.bus[63:32]), 64'(0));
    chk("single_fips", 64'(e0.fips),      64'(2'b01));
    e0.req = 2'b00;
    step();
    chk("single_cnt",  64'(cnt0),  64'(1));
    chk("single_idle", 64'(busy0), 64'(0));
    chk("single_ack0", 64'(e0.ack), 64'(0));

    e0.req = 2'b10;
    repeat (5) step();
    chk("second_ack",  64'(e0.ack),        64'(2'b10));
    chk("second_word", 64'(e0.bus[63:32]), 64'(32'h8020_0003));
    chk("second_fips", 64'(e0.fips),       64'(2'b10));
    e0.req = 2'b00;
    step();
    chk("second_cnt", 64'(cnt0), 64'(2));

    // round-robin with both channels held
    w = lfsr_nx(lfsr_nx(32'h1));
    e0.req = 2'b11;
    for (int k = 1; k <= 23; k++) begin
      step();
      exp2 = (k % 6 == 5) ? (((k / 6) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      chk("rr_ack", 64'(e0.ack), 64'(exp2));
      if (exp2 != 2'b00) begin
        chk("rr_word", 64'((exp2 == 2'b01) ? e0.bus[31:0] : e0.bus[63:32]), 64'(w));
        w = lfsr_nx(w);
      end
    end
    e0.req = 2'b00;
    step();
    chk("rr_cnt", 64'(cnt0), 64'(6));

    // zero latency, seed 0, preloaded saturating counter
    e1.req = 3'b111;
    w = 32'h1;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k % 2 == 1) begin
        ch   = ((k - 1) / 2) % 3;
        exp3 = 3'(1 << ch);
        chk("zl_ack",  64'(e1.ack),             64'(exp3));
        chk("zl_fips", 64'(e1.fips),            64'(exp3));
        chk("zl_word", 64'(e1.bus[32*ch +: 32]), 64'(w));
        chk("zl_busy", 64'(busy1),              64'(1));
        w = lfsr_nx(w);
      end else begin
        chk("zl_gap",  64'(e1.ack), 64'(0));
        chk("zl_idle", 64'(busy1),  64'(0));
        chk("zl_sat",  64'(cnt1),   64'(16'hFFFF));
      end
    end
    e1.req = 3'b000;
    en1 = 1'b0;
    step();
    e1.req = 3'b111;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("dis_ack",  64'(e1.ack), 64'(0));
      chk("dis_busy", 64'(busy1),  64'(0));
    end
    e1.req = 3'b000; en1 = 1'b1;

    // reset while waiting
    e0.req = 2'b01;
    step(); step();
    rst = 1'b1;
    step();
    chk("midrst_busy", 64'(busy0), 64'(0));
    chk("midrst_cnt",  64'(cnt0),  64'(0));
    rst = 1'b0; e0.req = 2'b00;
    step();

    // drop req two cycles after grant
    e0.req = 2'b01;
    step(); step();
    e0.req = 2'b00;
    chk("abort_busy_pre", 64'(busy0), 64'(1));
    step();
    chk("abort_busy_post", 64'(busy0), 64'(0));
    for (int k = 0; k < 6; k++) begin
      step();
      chk("abort_noack", 64'(e0.ack), 64'(0));
    end
    chk("abort_cnt", 64'(cnt0), 64'(0));
    e0.req = 2'b01;
    repeat (5) step();
    chk("after_abort_ack",  64'(e0.ack),       64'(2'b01));
    chk("after_abort_word", 64'(e0.bus[31:0]), 64'(32'h0000_0001));
    e0.req = 2'b00;
    step();

    // enable dropped mid-wait aborts and blocks new grants
    e0.req = 2'b10;
    step(); step();
    en0 = 1'b0;
    step();
    chk("en_abort_busy", 64'(busy0), 64'(0));
    for (int k = 0; k < 8; k++) begin
      step();
      chk("en_off_ack", 64'(e0.ack), 64'(0));
    end
    chk("en_off_cnt", 64'(cnt0), 64'(1));
    e0.req = 2'b00; en0 = 1'b1;
    step();

`ifdef AST_EDN_STUB_ERR_INJ_EN
    rst = 1'b1;
    step();
    rst = 1'b0; e0.req = 2'b01;
    repeat (4) step();
    err0 = 1'b1;
    step();
    err0 = 1'b0;
    chk("inj_ack",  64'(e0.ack),       64'(2'b01));
    chk("inj_fips", 64'(e0.fips),      64'(0));
    chk("inj_word", 64'(e0.bus[31:0]), 64'(32'hFFFF_FFFE));
    e0.req = 2'b00;
    step();
    e0.req = 2'b01;
    repeat (5) step();
    chk("inj_next_word", 64'(e0.bus[31:0]), 64'(32'h8020_0003));
    chk("inj_next_fips", 64'(e0.fips),      64'(2'b01));
    e0.req = 2'b00;
    step();
`endif

    // randomized traffic against a transaction-level model
    rst = 1'b1;
    step();
    rst = 1'b0;
    pend = 2'b00; m_busy = 1'b0; free_from = 0; rr_m = 0; cnt_m = 0;
    lf_m = 32'h1; m_ch = 0; m_ack = 0;
    for (int c = 0; c < 600; c++) begin
      if (c > 0) step();
      exp2 = (m_busy && c == m_ack) ? 2'(1 << m_ch) : 2'b00;
      chk("rnd_ack", 64'(e0.ack), 64'(exp2));
      chk("rnd_cnt", 64'(cnt0),   64'(cnt_m));
      if (exp2 != 2'b00) begin
        chk("rnd_word", 64'((m_ch == 0) ? e0.bus[31:0] : e0.bus[63:32]), 64'(lf_m));
        chk("rnd_fips", 64'(e0.fips), 64'(exp2));
        lf_m      = lfsr_nx(lf_m);
        rr_m      = (m_ch + 1) % 2;
        cnt_m     = cnt_m + 1;
        pend[m_ch] = 1'b0;
        m_busy    = 1'b0;
        free_from = c + 1;
      end else begin
        chk("rnd_quiet", 64'(e0.bus), 64'(0));
      end
      for (int i = 0; i < 2; i++)
        if (!pend[i] && $urandom_range(3) == 0) pend[i] = 1'b1;
      e0.req = pend;
      if (!m_busy && c >= free_from && pend != 2'b00) begin
        found = 1'b0;
        for (int i = 0; i < 2; i++) begin
          if (!found && pend[(rr_m + i) % 2]) begin
            found = 1'b1;
            m_ch  = (rr_m + i) % 2;
          end
        end
        m_ack  = c + 4 + 1;
        m_busy = 1'b1;
      end
    end
    e0.req = 2'b00;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
